// File: rtl/temporizador_pkg.sv
// Shared types and pin-map constants for the loadable 8-bit down-counter tile.
package temporizador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned UI_LOAD  = 0;
  localparam int unsigned UI_START = 1;
  localparam int unsigned UI_PAUSE = 2;
  localparam int unsigned UI_AUTO  = 3;

  localparam int unsigned UIO_ZERO = 4;
  localparam int unsigned UIO_RUN  = 5;
  localparam int unsigned UIO_DONE = 6;

  localparam int unsigned PRESCALE_DEFAULT = 4;
  localparam logic [7:0]  UIO_OE_CONST     = 8'hF0;

endpackage

// File: rtl/down_counter_8bits.sv
// Count register with load, decrement, terminal reload/clear and a one-cycle zero pulse.
module down_counter_8bits (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  input  logic       auto_i,
  input  logic [7:0] rld_i,
  output logic [7:0] count_o,
  output logic       zero_pulse_o
);

  logic [7:0] count_q, count_d;
  logic       zp_q, zp_d;

  // Decrementing from 1 is the terminal event, so the count never wraps below 0.
  always_comb begin
    count_d = count_q;
    zp_d    = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      if (count_q == 8'd1) begin
        zp_d    = 1'b1;
        count_d = auto_i ? rld_i : '0;
      end else begin
        count_d = count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      zp_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      zp_q    <= zp_d;
    end
  end

  assign count_o      = count_q;
  assign zero_pulse_o = zp_q;

endmodule

// File: rtl/tt_um_temporizador_8bits.sv
// Tiny Tapeout down-counter/timer top: synchronisers, edge detect, FSM, prescaler, pin map.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module tt_um_temporizador_8bits
  import temporizador_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] ctl_s1_q, ctl_s2_q;
  logic [7:0] val_s1_q, val_s2_q;
  logic       ld_prev_q, st_prev_q;
  logic [7:0] rld_q;
  state_e     state_q, state_d;
  logic [7:0] count;
  logic       zero_pulse;
  logic       running, done;
  logic       load_edge, start_edge, pause, auto_mode, tick;
  logic       run_tick, restart, cnt_load, cnt_dec;
  logic [7:0] cnt_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_s1_q  <= '0;
      ctl_s2_q  <= '0;
      val_s1_q  <= '0;
      val_s2_q  <= '0;
      ld_prev_q <= 1'b0;
      st_prev_q <= 1'b0;
    end else begin
      ctl_s1_q  <= ui_in[3:0];
      ctl_s2_q  <= ctl_s1_q;
      val_s1_q  <= {ui_in[7:4], uio_in[3:0]};
      val_s2_q  <= val_s1_q;
      ld_prev_q <= ctl_s2_q[UI_LOAD];
      st_prev_q <= ctl_s2_q[UI_START];
    end
  end

  assign load_edge  = ctl_s2_q[UI_LOAD] & ~ld_prev_q;
  assign start_edge = ctl_s2_q[UI_START] & ~st_prev_q;
  assign pause      = ctl_s2_q[UI_PAUSE];
  assign auto_mode  = ctl_s2_q[UI_AUTO];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rld_q <= '0;
    end else if (load_edge) begin
      rld_q <= val_s2_q;
    end
  end

`ifdef TIMER_PRESCALER_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q;
  logic          run_entry;

  assign run_entry = (state_q != RUN) && (state_d == RUN);
  assign tick      = (presc_q == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || load_edge || run_entry) begin
      presc_q <= '0;
    end else if ((state_q == RUN) && !pause) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Load edge has absolute priority; restart from DONE reuses the counter's load path with rld.
  assign run_tick = (state_q == RUN) & ~pause & tick;
  assign restart  = (state_q == DONE) & ~pause & start_edge & (rld_q != '0);
  assign cnt_load = load_edge | restart;
  assign cnt_val  = load_edge ? val_s2_q : rld_q;
  assign cnt_dec  = run_tick & ~load_edge;

  down_counter_8bits u_cnt (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (cnt_load),
    .load_val_i  (cnt_val),
    .dec_i       (cnt_dec),
    .auto_i      (auto_mode),
    .rld_i       (rld_q),
    .count_o     (count),
    .zero_pulse_o(zero_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_edge) begin
      state_d = IDLE;
    end else if (!pause) begin
      unique case (state_q)
        IDLE:    if (start_edge && (count != '0)) state_d = RUN;
        RUN:     if (tick && (count == 8'd1) && !auto_mode) state_d = DONE;
        DONE:    if (restart) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state_q == RUN);
    done    = (state_q == DONE);
  end

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_ZERO] = zero_pulse;
    uio_out[UIO_RUN]  = running;
    uio_out[UIO_DONE] = done;
  end

  assign uo_out = count;
  assign uio_oe = UIO_OE_CONST;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4], PRESCALE[0]};

endmodule

// File: tb/tb_tt_um_temporizador_8bits.sv
// Directed plus randomized bench with a cycle-level behavioural model of the timer.
module tb_tt_um_temporizador_8bits;

`ifdef TIMER_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad   = 0;

  // Model state: pin history (index 1 = newest sample), count, reload, phase 0/1/2 = idle/run/done.
  logic [3:0] hc [1:3];
  logic [7:0] hv [1:2];
  int m_cnt, m_rld, m_ph, m_zp, m_presc;

  tt_um_temporizador_8bits #(.PRESCALE(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic ld, st;
    ld = hc[2][0] & ~hc[3][0];
    st = hc[2][1] & ~hc[3][1];
    if (!rst_n) begin
      m_cnt = 0; m_rld = 0; m_ph = 0; m_zp = 0; m_presc = 0;
      for (int i = 1; i <= 3; i++) hc[i] = '0;
      hv[1] = '0; hv[2] = '0;
      return;
    end
    m_zp = 0;
    if (ld) begin
      m_cnt = hv[2]; m_rld = hv[2]; m_ph = 0; m_presc = 0;
    end else if (!hc[2][2]) begin
      if (m_ph == 0) begin
        if (st && m_cnt != 0) begin m_ph = 1; m_presc = 0; end
      end else if (m_ph == 1) begin
        if (m_presc == P - 1) begin
          m_presc = 0;
          if (m_cnt == 1) begin
            m_zp = 1;
            if (hc[2][3]) m_cnt = m_rld;
            else begin m_cnt = 0; m_ph = 2; end
          end else begin
            m_cnt = m_cnt - 1;
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end else begin
        if (st && m_rld != 0) begin m_cnt = m_rld; m_ph = 1; m_presc = 0; end
      end
    end
    hc[3] = hc[2]; hc[2] = hc[1]; hc[1] = ui_in[3:0];
    hv[2] = hv[1]; hv[1] = {ui_in[7:4], uio_in[3:0]};
  endtask

  task automatic step();
    logic [7:0] exp_st;
    @(posedge clk);
    model_edge();
    #1;
    exp_st = {1'b0, (m_ph == 2), (m_ph == 1), (m_zp == 1), 4'b0000};
    check("model_count", uo_out, 8'(m_cnt));
    check("model_status", uio_out, exp_st);
    check("uio_oe", uio_oe, 8'hF0);
  endtask

  task automatic set_val(input logic [7:0] v);
    ui_in[7:4]  = v[7:4];
    uio_in[3:0] = v[3:0];
    uio_in[7:4] = 4'($urandom);
  endtask

  task automatic do_load(input logic [7:0] v);
    set_val(v);
    ui_in[0] = 1'b1;
    repeat (3) step();
    ui_in[0] = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    ui_in[1] = 1'b1;
    step();
    ui_in[1] = 1'b0;
    step();
    while (!uio_out[5] && n < 20) begin
      step();
      n++;
    end
    check(tag, {7'b0, uio_out[5]}, 8'd1);
  endtask

  initial begin
    ena = 1'b1; rst_n = 1'b0; ui_in = '0; uio_in = '0;
    for (int i = 1; i <= 3; i++) hc[i] = '0;
    hv[1] = '0; hv[2] = '0;
    m_cnt = 0; m_rld = 0; m_ph = 0; m_zp = 0; m_presc = 0;
    step(); step();
    check("reset_count", uo_out, 8'h00);
    check("reset_status", uio_out, 8'h00);
    rst_n = 1'b1;
    step();

    // One-shot countdown from 5.
    do_load(8'h05);
    wait_run("run5_start");
    check("run5_first", uo_out, 8'd5);
    for (int k = 4; k >= 0; k--) begin
      repeat (P) step();
      check("run5_count", uo_out, 8'(k));
      check("run5_status", uio_out, (k == 0) ? 8'h50 : 8'h20);
    end
    step();
    check("run5_done", uio_out, 8'h40);

    // Auto-reload from 3.
    ui_in[3] = 1'b1;
    do_load(8'h03);
    wait_run("auto_start");
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        repeat (P) step();
        check("auto_count", uo_out, (j == 2) ? 8'd3 : 8'(2 - j));
        check("auto_status", uio_out, (j == 2) ? 8'h30 : 8'h20);
      end
    end
    ui_in[3] = 1'b0;

    // Pause in the middle of a countdown from 10.
    do_load(8'h0A);
    wait_run("pause_start");
    repeat (3 * P) step();
    ui_in[2] = 1'b1;
    repeat (8) step();
    ui_in[2] = 1'b0;
    repeat (3) step();

    // Load and start together while running: load wins.
    set_val(8'h20);
    ui_in[0] = 1'b1; ui_in[1] = 1'b1;
    repeat (3) step();
    check("ldst_count", uo_out, 8'h20);
    check("ldst_status", uio_out, 8'h00);
    ui_in[0] = 1'b0; ui_in[1] = 1'b0;
    step();
    wait_run("ldst_restart");
    check("ldst_first", uo_out, 8'h20);

    // Reset in the middle of a count from 0x40.
    do_load(8'h40);
    wait_run("rst_start");
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midrst_count", uo_out, 8'h00);
    check("midrst_status", uio_out, 8'h00);
    rst_n = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      ui_in      = 8'($urandom);
      ui_in[0]   = ($urandom_range(0, 19) == 0);
      ui_in[1]   = ($urandom_range(0, 7) == 0);
      ui_in[2]   = ($urandom_range(0, 9) == 0);
      ui_in[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      uio_in     = 8'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_temporizador_8bits.md
# tt_um_temporizador_8bits

Loadable 8-bit down-counter/timer tile for the Tiny Tapeout harness, the counterpart of the team's free-running up-counter with carry. Instead of counting up and emitting a carry, it takes a terminal value from the pins, counts it down to zero, and signals a borrow/zero event. It sits directly behind the standard TT top-level pin set. Its count is observable on `uo_out` and its status on the upper `uio` pins.

## Interface
- `PRESCALE`, default 4: clocks per decrement tick; legal range 1..256. Only used when `TIMER_PRESCALER_EN` is defined.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `ui_in`  in  8  controls:
  - [0] `load`: rising edge loads the reload value.
  - [1] `start`: rising edge starts the count.
  - [2] `pause`: level; freezes the count.
  - [3] `auto`: level; auto-reload mode.
  - [7:4] reload value bits [7:4].
- `uo_out`  out  8  current count.
- `uio_in`  in  8  bits [3:0] are reload value bits [3:0]; bits [7:4] are unused.
- `uio_out`  out  8  status:
  - [4] `zero_pulse`
  - [5] `running`
  - [6] `done`
  - [7] constant 0
  - [3:0] constant 0
- `uio_oe`  out  8  constant 8'b1111_0000.
- `ena`  in  1  ignored.

## Operation
- Input synchronisation:
  - `ui_in[3:0]` and the 8-bit reload value pass through 2-FF synchronisers.
  - `load` and `start` are edge-detected on the synchronised signal (current & ~previous).
- Reload register `rld[7:0]` captures the synchronised reload value on a `load` edge.
- States: IDLE, RUN, DONE.
- Any state, `load` edge:
  - `count <= value`, `rld <= value`, state <= IDLE.
  - Overrides `start`, tick and pause in the same cycle.
- IDLE:
  - `start` edge with count != 0: go to RUN.
  - `start` edge with count == 0: ignored.
- RUN:
  - On each un-paused tick: count decrements by 1.
  - Tick with count == 1:
    - `zero_pulse` = 1 for exactly one cycle.
    - If `auto` = 0: count <= 0, go to DONE.
    - If `auto` = 1: count <= `rld`, stay in RUN. With `rld` == 1 this gives one pulse per tick.
  - `start` edges are ignored.
- DONE:
  - Count holds at 0.
  - `start` edge with `rld` != 0: count <= `rld`, go to RUN.
  - `start` edge with `rld` == 0: ignored.
- Pause (synchronised `ui_in[2]` = 1): count, state and prescaler all freeze. `load` is still honoured.
- Arithmetic: 8-bit unsigned. Count never wraps below 0, because a decrement from 1 is the terminal event.
- Status outputs:
  - `running` = (state == RUN).
  - `done` = (state == DONE).
  - All outputs are registered or derived directly from registers.

## Timing
- Reset values (on a clock edge with `rst_n` = 0): count = 0, `rld` = 0, state IDLE, synchronisers = 0, prescaler = 0, `zero_pulse`/`running`/`done` = 0. `uio_oe` is constant.
- Control latency:
  - A pin sampled high at edge E0 takes effect in the registers at edge E2.
  - The result is visible on outputs after E2.
  - The same latency applies to `pause` and `auto`.
- Without the prescaler:
  - The first decrement happens on the edge after the RUN entry edge.
  - Count N reaches 0 after N clocks in RUN.
  - `zero_pulse` and `done` rise on the same edge that count becomes 0.
- Reset mid-run takes priority over every other event, with no residual pulse.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - A prescaler counter runs 0..`PRESCALE`-1 and ticks when it reaches `PRESCALE`-1.
  - It clears on reset, on a `load` edge and on RUN entry.
  - It holds while paused or outside RUN.
  - Count N therefore lasts N×`PRESCALE` clocks.
- Not defined: tick = 1 every clock, and `PRESCALE` is unused.

## Structure
- Package `temporizador_pkg` holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - `ui_in` bit index constants (LOAD=0, START=1, PAUSE=2, AUTO=3);
  - `uio_out` bit index constants (ZERO=4, RUN=5, DONE=6);
  - the `PRESCALE` default;
  - the `uio_oe` constant.
- Sub-module `down_counter_8bits` contains the count register, load/decrement logic and the zero-detect/`zero_pulse` register.
- The top level holds the synchronisers, edge detect, FSM, prescaler and pin mapping.

## Test plan
- Reset, then load 0x05 and start (no prescaler, `auto` = 0):
  - `uo_out` reads 5, 4, 3, 2, 1, 0 on consecutive clocks;
  - `zero_pulse` is high for one cycle when count reaches 0;
  - `done` is then 1 and `running` is 0.
- Load 0x03, `auto` = 1, start:
  - count sequence 3, 2, 1, 3, 2, 1, …;
  - `zero_pulse` every 3rd clock;
  - `done` stays 0.
- Load 0x0A, start, raise `pause` after count reaches 7:
  - count holds at 7 for the whole pause;
  - after `pause` falls, the count resumes 6, 5, … with the 2-cycle synchroniser delay.
- Assert `load` (value 0x20) and `start` in the same cycle while in RUN:
  - count = 0x20, state IDLE, `running` = 0;
  - a later `start` begins the countdown from 0x20.
- Deassert `rst_n` mid-count (count 0x40):
  - next edge: count 0, all status outputs 0, `uio_oe` = 0xF0.
- With `TIMER_PRESCALER_EN` and `PRESCALE` = 4: load 2, start → count 2→1→0 over 8 clocks, with a single `zero_pulse`.
